i2c_slave_regbank: RTL and testbench

- Clocked, multi-address register-bank memory behind the I2C slave byte engine; replaces the enable-edge memory.
- Matches the received device address against ADDRESSNUM entries (all entries, not just the first); each entry owns a bank of DEPTH bytes.
- Follows I2C combined-format convention: first write byte after address = register pointer; later bytes read/write at pointer with auto-increment and wrap.
- Exposes whole bank contents in parallel for system logic.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_slave_regbank_if.sv | 35 +++
 rtl/i2c_addr_match.sv | 27 ++
 rtl/i2c_slave_regbank.sv | 149 ++++++++++++++
 tb/tb_i2c_slave_regbank.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave register bank and its helpers.
// Holds FSM state encoding, R/W bit values and default address widths.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PTR    = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int ADDR_LEN_DEF = 7;
    localparam int ADDR_NUM_DEF = 2;
    localparam int DEPTH_DEF    = 4;

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_slave_regbank_if.sv
// Byte-engine <-> register-bank bus for the I2C slave.
// master: byte engine (Start/Stop/AddrValid/AddrByte/WrValid/WrData/RdReq),
// slave: register bank (AddressFound/BankId/WrAck/RdData/RdValid).
interface i2c_slave_regbank_if #(
    parameter int ADDRESSLENGTH = 7,
    parameter int ADDRESSNUM    = 2
);
    import i2c_pkg::*;

    localparam int BID_W = idx_width(ADDRESSNUM);

    logic                     Start;
    logic                     Stop;
    logic                     AddrValid;
    logic [ADDRESSLENGTH:0]   AddrByte;
    logic                     AddressFound;
    logic [BID_W-1:0]         BankId;
    logic                     WrValid;
    logic [7:0]               WrData;
    logic                     WrAck;
    logic                     RdReq;
    logic [7:0]               RdData;
    logic                     RdValid;

    modport master (
        output Start, Stop, AddrValid, AddrByte, WrValid, WrData, RdReq,
        input  AddressFound, BankId, WrAck, RdData, RdValid
    );

    modport slave (
        input  Start, Stop, AddrValid, AddrByte, WrValid, WrData, RdReq,
        output AddressFound, BankId, WrAck, RdData, RdValid
    );

endinterface

// File: rtl/i2c_addr_match.sv
// Combinational priority matcher: compares addr against every list entry.
// Ports: addr_list (entries packed LSB-first), addr -> hit, idx (lowest match).
module i2c_addr_match #(
    parameter int ADDRESSLENGTH = 7,
    parameter int ADDRESSNUM    = 2,
    parameter int IDX_W         = 1
) (
    input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] addr_list,
    input  logic [ADDRESSLENGTH-1:0]            addr,
    output logic                                hit,
    output logic [IDX_W-1:0]                    idx
);

    // Scan from the top down so the lowest matching index is the last
    // one written and therefore wins on duplicates.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = ADDRESSNUM - 1; k >= 0; k--) begin
            if (addr_list[k*ADDRESSLENGTH +: ADDRESSLENGTH] == addr) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/i2c_slave_regbank.sv
// Multi-address register bank behind the I2C slave byte engine.
// Ports: Clk, Reset (async high), AddressList, bus (slave side of
// i2c_slave_regbank_if), Data (all banks flattened), and WriteProtect
// when built with I2C_REGBANK_WPROT_EN (protects upper half of each bank).
module i2c_slave_regbank
    import i2c_pkg::*;
#(
    parameter int ADDRESSLENGTH = ADDR_LEN_DEF,
    parameter int ADDRESSNUM    = ADDR_NUM_DEF,
    parameter int DEPTH         = DEPTH_DEF,
    parameter int PTR_W         = $clog2(DEPTH)
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] AddressList,
`ifdef I2C_REGBANK_WPROT_EN
    input  logic                              WriteProtect,
`endif
    i2c_slave_regbank_if.slave                bus,
    output logic [8*DEPTH*ADDRESSNUM-1:0]     Data
);

    localparam int BID_W = idx_width(ADDRESSNUM);

    typedef logic [ADDRESSNUM-1:0][DEPTH-1:0][7:0] bank_t;

    state_t           state_q, state_d;
    logic             af_q, af_d;
    logic [BID_W-1:0] bid_q, bid_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    bank_t            bank_q, bank_d;
    logic             wrack_q, wrack_d;
    logic             rdv_q, rdv_d;
    logic [7:0]       rdd_q, rdd_d;

    logic             hit;
    logic [BID_W-1:0] hit_idx;
    logic             ptr_load;
    logic             wr_byte;
    logic             rd_byte;
    logic             wr_keep;

    i2c_addr_match #(
        .ADDRESSLENGTH (ADDRESSLENGTH),
        .ADDRESSNUM    (ADDRESSNUM),
        .IDX_W         (BID_W)
    ) u_match (
        .addr_list (AddressList),
        .addr      (bus.AddrByte[ADDRESSLENGTH:1]),
        .hit       (hit),
        .idx       (hit_idx)
    );

    assign ptr_load = (state_q == ST_PTR)   && bus.WrValid;
    assign wr_byte  = (state_q == ST_WRITE) && bus.WrValid;
    assign rd_byte  = (state_q == ST_READ)  && bus.RdReq;

`ifdef I2C_REGBANK_WPROT_EN
    // Pointer MSB set means pointer >= DEPTH/2 (DEPTH is a power of two).
    assign wr_keep = !(WriteProtect && ptr_q[PTR_W-1]);
`else
    assign wr_keep = 1'b1;
`endif

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; bus control events outrank data handshakes.
    always_comb begin
        state_d = state_q;
        if (bus.Stop || bus.Start) begin
            state_d = ST_IDLE;
        end else if (bus.AddrValid) begin
            if (!hit)
                state_d = ST_IGNORE;
            else if (bus.AddrByte[0] == RW_READ)
                state_d = ST_READ;
            else
                state_d = ST_PTR;
        end else if (ptr_load) begin
            state_d = ST_WRITE;
        end
    end

    // Output / datapath logic
    always_comb begin
        af_d    = af_q;
        bid_d   = bid_q;
        ptr_d   = ptr_q;
        bank_d  = bank_q;
        wrack_d = 1'b0;
        rdv_d   = 1'b0;
        rdd_d   = rdd_q;
        if (bus.Stop || bus.Start) begin
            af_d = 1'b0;
        end else if (bus.AddrValid) begin
            af_d = hit;
            if (hit) bid_d = hit_idx;
        end else begin
            if (ptr_load) begin
                ptr_d   = bus.WrData[PTR_W-1:0];
                wrack_d = 1'b1;
            end
            if (wr_byte) begin
                if (wr_keep) begin
                    bank_d[bid_q][ptr_q] = bus.WrData;
                    wrack_d              = 1'b1;
                end
                ptr_d = ptr_q + 1'b1;
            end
            if (rd_byte) begin
                rdd_d = bank_q[bid_q][ptr_q];
                rdv_d = 1'b1;
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            af_q    <= 1'b0;
            bid_q   <= '0;
            ptr_q   <= '0;
            bank_q  <= '0;
            wrack_q <= 1'b0;
            rdv_q   <= 1'b0;
            rdd_q   <= 8'h00;
        end else begin
            af_q    <= af_d;
            bid_q   <= bid_d;
            ptr_q   <= ptr_d;
            bank_q  <= bank_d;
            wrack_q <= wrack_d;
            rdv_q   <= rdv_d;
            rdd_q   <= rdd_d;
        end
    end

    assign bus.AddressFound = af_q;
    assign bus.BankId       = bid_q;
    assign bus.WrAck        = wrack_q;
    assign bus.RdValid      = rdv_q;
    assign bus.RdData       = rdd_q;
    assign Data             = bank_q;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Self-checking bench for i2c_slave_regbank (DEPTH=4, two addresses).
// Covers WriteProtect scenario when built with I2C_REGBANK_WPROT_EN.
module tb_i2c_slave_regbank;

    localparam int AL = 7;
    localparam int AN = 2;
    localparam int DP = 4;
    localparam int DW = 8 * DP * AN;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [AL*AN-1:0]  AddressList;
    logic [DW-1:0]     Data;
`ifdef I2C_REGBANK_WPROT_EN
    logic              WriteProtect;
`endif

    i2c_slave_regbank_if #(.ADDRESSLENGTH(AL), .ADDRESSNUM(AN)) bus();

    i2c_slave_regbank #(
        .ADDRESSLENGTH (AL),
        .ADDRESSNUM    (AN),
        .DEPTH         (DP)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .AddressList  (AddressList),
`ifdef I2C_REGBANK_WPROT_EN
        .WriteProtect (WriteProtect),
`endif
        .bus          (bus),
        .Data         (Data)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [DP*AN];
    logic [7:0] rd_q [$];
    int         mptr;

    function automatic logic [DW-1:0] mdl_vec();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < DP*AN; i++) v[i*8 +: 8] = mdl[i];
        return v;
    endfunction

    task automatic idle_bus();
        bus.Start     = 1'b0;
        bus.Stop      = 1'b0;
        bus.AddrValid = 1'b0;
        bus.AddrByte  = '0;
        bus.WrValid   = 1'b0;
        bus.WrData    = 8'h00;
        bus.RdReq     = 1'b0;
    endtask

    task automatic send_addr(input logic [AL-1:0] a, input logic rw);
        @(negedge Clk);
        bus.AddrByte  = {a, rw};
        bus.AddrValid = 1'b1;
        @(negedge Clk);
        bus.AddrValid = 1'b0;
    endtask

    task automatic send_wr(input logic [7:0] d);
        @(negedge Clk);
        bus.WrData  = d;
        bus.WrValid = 1'b1;
        @(negedge Clk);
        bus.WrValid = 1'b0;
    endtask

    task automatic send_rd();
        @(negedge Clk);
        bus.RdReq = 1'b1;
        @(negedge Clk);
        bus.RdReq = 1'b0;
    endtask

    task automatic send_start();
        @(negedge Clk);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
    endtask

    task automatic send_stop();
        @(negedge Clk);
        bus.Stop = 1'b1;
        @(negedge Clk);
        bus.Stop = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle_bus();
        AddressList = {7'h52, 7'h50};
        for (int i = 0; i < DP*AN; i++) mdl[i] = 8'h00;
        repeat (2) @(negedge Clk);
        checks++;
        if (bus.AddressFound !== 1'b0 || bus.BankId !== 1'b0) begin
            errors++;
            $display("FAIL reset_af_bid got af=%b bid=%b want 0 0",
                     bus.AddressFound, bus.BankId);
        end
        checks++;
        if (bus.WrAck !== 1'b0 || bus.RdValid !== 1'b0 || bus.RdData !== 8'h00) begin
            errors++;
            $display("FAIL reset_pulses got ack=%b rdv=%b rdd=%h want 0 0 00",
                     bus.WrAck, bus.RdValid, bus.RdData);
        end
        checks++;
        if (Data !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", Data);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_match();
        send_addr(7'h52, 1'b0);
        checks++;
        if (bus.AddressFound !== 1'b1 || bus.BankId !== 1'b1) begin
            errors++;
            $display("FAIL match_52 got af=%b bid=%b want 1 1",
                     bus.AddressFound, bus.BankId);
        end
        send_wr(8'h00);
        checks++;
        if (bus.WrAck !== 1'b1) begin
            errors++;
            $display("FAIL match_ptr_ack got %b want 1", bus.WrAck);
        end
        send_stop();
        send_addr(7'h33, 1'b0);
        checks++;
        if (bus.AddressFound !== 1'b0 || bus.BankId !== 1'b1) begin
            errors++;
            $display("FAIL nomatch_33 got af=%b bid=%b want 0 1",
                     bus.AddressFound, bus.BankId);
        end
        send_wr(8'h5A);
        checks++;
        if (bus.WrAck !== 1'b0 || Data !== mdl_vec()) begin
            errors++;
            $display("FAIL nomatch_wr got ack=%b data=%h want 0 %h",
                     bus.WrAck, Data, mdl_vec());
        end
        send_stop();
    endtask

    task automatic test_write_wrap();
        logic [7:0] bytes [3];
        bytes[0] = 8'hAA;
        bytes[1] = 8'hBB;
        bytes[2] = 8'hCC;
        send_addr(7'h50, 1'b0);
        send_wr(8'h02);
        mptr = 2;
        checks++;
        if (bus.WrAck !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ptr_ack got %b want 1", bus.WrAck);
        end
        for (int i = 0; i < 3; i++) begin
            send_wr(bytes[i]);
            mdl[mptr] = bytes[i];
            mptr = (mptr + 1) % DP;
            checks++;
            if (bus.WrAck !== 1'b1) begin
                errors++;
                $display("FAIL wrap_ack%0d got %b want 1", i, bus.WrAck);
            end
        end
        checks++;
        if (Data !== mdl_vec()) begin
            errors++;
            $display("FAIL wrap_data got %h want %h", Data, mdl_vec());
        end
        send_stop();
    endtask

    task automatic test_read_restart();
        send_start();
        send_addr(7'h50, 1'b0);
        send_wr(8'h02);
        mptr = 2;
        send_start();
        send_addr(7'h50, 1'b1);
        checks++;
        if (bus.AddressFound !== 1'b1 || bus.BankId !== 1'b0) begin
            errors++;
            $display("FAIL rs_match got af=%b bid=%b want 1 0",
                     bus.AddressFound, bus.BankId);
        end
        for (int i = 0; i < 3; i++) begin
            rd_q.push_back(mdl[mptr]);
            mptr = (mptr + 1) % DP;
            send_rd();
            checks++;
            if (bus.RdValid !== 1'b1 || bus.RdData !== rd_q[0]) begin
                errors++;
                $display("FAIL rs_rd%0d got v=%b d=%h want 1 %h",
                         i, bus.RdValid, bus.RdData, rd_q[0]);
            end
            void'(rd_q.pop_front());
            @(negedge Clk);
            checks++;
            if (bus.RdValid !== 1'b0) begin
                errors++;
                $display("FAIL rs_pulse%0d got %b want 0", i, bus.RdValid);
            end
        end
        send_stop();
        send_rd();
        checks++;
        if (bus.RdValid !== 1'b0) begin
            errors++;
            $display("FAIL rd_idle got %b want 0", bus.RdValid);
        end
    endtask

    task automatic test_stop_addr_same();
        @(negedge Clk);
        bus.Stop      = 1'b1;
        bus.AddrValid = 1'b1;
        bus.AddrByte  = {7'h50, 1'b0};
        @(negedge Clk);
        bus.Stop      = 1'b0;
        bus.AddrValid = 1'b0;
        checks++;
        if (bus.AddressFound !== 1'b0) begin
            errors++;
            $display("FAIL stop_addr_af got %b want 0", bus.AddressFound);
        end
        send_wr(8'h07);
        checks++;
        if (bus.WrAck !== 1'b0) begin
            errors++;
            $display("FAIL stop_addr_wr got %b want 0", bus.WrAck);
        end
    endtask

    task automatic test_back_to_back();
        send_addr(7'h52, 1'b0);
        @(negedge Clk);
        bus.WrData  = 8'h00;
        bus.WrValid = 1'b1;
        mptr = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checks++;
            if (bus.WrAck !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ack%0d got %b want 1", i, bus.WrAck);
            end
            if (i < 4) begin
                bus.WrData = 8'h10 + 8'(i);
                mdl[DP + mptr] = 8'h10 + 8'(i);
                mptr = (mptr + 1) % DP;
            end else begin
                bus.WrValid = 1'b0;
            end
        end
        checks++;
        if (Data !== mdl_vec()) begin
            errors++;
            $display("FAIL b2b_data got %h want %h", Data, mdl_vec());
        end
        send_start();
        send_addr(7'h52, 1'b0);
        send_wr(8'hF7);
        mptr = 3;
        send_start();
        send_addr(7'h52, 1'b1);
        @(negedge Clk);
        bus.RdReq = 1'b1;
        rd_q.push_back(mdl[DP + mptr]);
        mptr = (mptr + 1) % DP;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            checks++;
            if (bus.RdValid !== 1'b1 || bus.RdData !== rd_q[0]) begin
                errors++;
                $display("FAIL b2b_rd%0d got v=%b d=%h want 1 %h",
                         i, bus.RdValid, bus.RdData, rd_q[0]);
            end
            void'(rd_q.pop_front());
            if (i < 3) begin
                rd_q.push_back(mdl[DP + mptr]);
                mptr = (mptr + 1) % DP;
            end else begin
                bus.RdReq = 1'b0;
            end
        end
        send_stop();
    endtask

    task automatic test_reset_mid();
        send_addr(7'h52, 1'b0);
        send_wr(8'h01);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        for (int i = 0; i < DP*AN; i++) mdl[i] = 8'h00;
        checks++;
        if (bus.AddressFound !== 1'b0 || bus.BankId !== 1'b0
            || bus.RdData !== 8'h00 || bus.WrAck !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_out got af=%b bid=%b rdd=%h ack=%b want 0 0 00 0",
                     bus.AddressFound, bus.BankId, bus.RdData, bus.WrAck);
        end
        checks++;
        if (Data !== mdl_vec()) begin
            errors++;
            $display("FAIL rstmid_data got %h want %h", Data, mdl_vec());
        end
        @(negedge Clk);
        Reset = 1'b0;
        send_wr(8'h44);
        checks++;
        if (bus.WrAck !== 1'b0 || Data !== mdl_vec()) begin
            errors++;
            $display("FAIL rstmid_wr got ack=%b data=%h want 0 %h",
                     bus.WrAck, Data, mdl_vec());
        end
    endtask

`ifdef I2C_REGBANK_WPROT_EN
    task automatic test_wprot();
        logic [7:0] bytes [3];
        logic       acks [3];
        bytes[0] = 8'h11; acks[0] = 1'b1;
        bytes[1] = 8'h22; acks[1] = 1'b0;
        bytes[2] = 8'h33; acks[2] = 1'b0;
        WriteProtect = 1'b1;
        send_addr(7'h50, 1'b0);
        send_wr(8'h01);
        checks++;
        if (bus.WrAck !== 1'b1) begin
            errors++;
            $display("FAIL wp_ptr_ack got %b want 1", bus.WrAck);
        end
        mdl[1] = 8'h11;
        for (int i = 0; i < 3; i++) begin
            send_wr(bytes[i]);
            checks++;
            if (bus.WrAck !== acks[i]) begin
                errors++;
                $display("FAIL wp_ack%0d got %b want %b", i, bus.WrAck, acks[i]);
            end
        end
        checks++;
        if (Data !== mdl_vec()) begin
            errors++;
            $display("FAIL wp_data got %h want %h", Data, mdl_vec());
        end
        send_stop();
        WriteProtect = 1'b0;
    endtask
`endif

    initial begin
`ifdef I2C_REGBANK_WPROT_EN
        WriteProtect = 1'b0;
`endif
        test_reset();
        test_match();
        test_write_wrap();
        test_read_restart();
        test_stop_addr_same();
        test_back_to_back();
        test_reset_mid();
`ifdef I2C_REGBANK_WPROT_EN
        test_wprot();
`endif
        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
